// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame controller: default geometry, the
// one-hot state encoding and the bit-reverse address helper.
package fft_pkg;

   localparam int FFT_N = 256;
   localparam int FFT_M = 8;
   localparam int FFT_W = 32;

   typedef enum logic [4:0] {
      ST_IDLE   = 5'b00001,
      ST_LOAD   = 5'b00010,
      ST_RUN    = 5'b00100,
      ST_ACK    = 5'b01000,
      ST_UNLOAD = 5'b10000
   } fft_state_t;

   // Reverses the low m bits of v; bits at and above m come back zero.
   function automatic logic [15:0] bit_rev(input logic [15:0] v, input int unsigned m);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < int'(m)) r[i] = v[int'(m) - 1 - i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// N-entry complex working buffer: two combinational read ports and two
// write ports, port B taking priority when both target the same entry.
module fft_frame_buf
   import fft_pkg::*;
#(
   parameter int N = FFT_N,
   parameter int M = FFT_M,
   parameter int W = FFT_W
) (
   input  logic                Clk,
   input  logic [M-1:0]        i_ra_addr,
   output logic signed [W-1:0] o_ra_re,
   output logic signed [W-1:0] o_ra_im,
   input  logic [M-1:0]        i_rb_addr,
   output logic signed [W-1:0] o_rb_re,
   output logic signed [W-1:0] o_rb_im,
   input  logic                i_wa_en,
   input  logic [M-1:0]        i_wa_addr,
   input  logic signed [W-1:0] i_wa_re,
   input  logic signed [W-1:0] i_wa_im,
   input  logic                i_wb_en,
   input  logic [M-1:0]        i_wb_addr,
   input  logic signed [W-1:0] i_wb_re,
   input  logic signed [W-1:0] i_wb_im
);

   logic signed [W-1:0] r_mem_re [N];
   logic signed [W-1:0] r_mem_im [N];

   // Contents deliberately survive reset; a new frame overwrites every entry.
   always_ff @(posedge Clk) begin
      if (i_wa_en) begin
         r_mem_re[i_wa_addr] <= i_wa_re;
         r_mem_im[i_wa_addr] <= i_wa_im;
      end
      if (i_wb_en) begin
         r_mem_re[i_wb_addr] <= i_wb_re;
         r_mem_im[i_wb_addr] <= i_wb_im;
      end
   end

   assign o_ra_re = r_mem_re[i_ra_addr];
   assign o_ra_im = r_mem_im[i_ra_addr];
   assign o_rb_re = r_mem_re[i_rb_addr];
   assign o_rb_im = r_mem_im[i_rb_addr];

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer around an external butterfly core: bit-reversed load, run, ack, unload.
// Optional FFT_FRAME_CTRL_OVF_EN adds a sticky per-frame overflow flag on port ovf.
module fft_frame_ctrl
   import fft_pkg::*;
#(
   parameter int N = FFT_N,
   parameter int M = FFT_M,
   parameter int W = FFT_W
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic signed [15:0]  s_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic signed [W-1:0] m_re,
   output logic signed [W-1:0] m_im,
   output logic                m_last,
   output logic                fft_start,
   output logic                fft_ack,
   input  logic                fft_proc,
   input  logic                fft_done,
   input  logic [M-1:0]        fft_i_top,
   input  logic [M-1:0]        fft_i_bot,
   output logic signed [W-1:0] fft_x_top_re,
   output logic signed [W-1:0] fft_x_top_im,
   output logic signed [W-1:0] fft_x_bot_re,
   output logic signed [W-1:0] fft_x_bot_im,
   input  logic signed [W-1:0] fft_y_top_re,
   input  logic signed [W-1:0] fft_y_top_im,
   input  logic signed [W-1:0] fft_y_bot_re,
   input  logic signed [W-1:0] fft_y_bot_im,
   output logic                busy
`ifdef FFT_FRAME_CTRL_OVF_EN
   ,
   output logic                ovf
`endif
);

   localparam logic [M-1:0] LAST_IDX = M'(N - 1);

   fft_state_t          r_state;
   logic [M-1:0]        r_in_idx;
   logic [M-1:0]        r_out_idx;
   logic                r_start;
   logic                r_ack;
   logic                r_m_valid;
   logic                r_m_last;
   logic signed [W-1:0] r_m_re;
   logic signed [W-1:0] r_m_im;

   logic                w_in_hs;
   logic                w_run_we;
   logic [M-1:0]        w_load_addr;
   logic [M-1:0]        w_rd_idx;
   logic [M-1:0]        w_ra_addr;
   logic [M-1:0]        w_wa_addr;
   logic signed [W-1:0] w_sext;
   logic signed [W-1:0] w_wa_re;
   logic signed [W-1:0] w_wa_im;

   assign s_ready  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
   assign busy     = (r_state != ST_IDLE);
   assign w_in_hs  = s_valid && s_ready;
   assign w_run_we = (r_state == ST_RUN) && fft_proc;

   assign w_load_addr = M'(bit_rev(16'(r_in_idx), M));
   assign w_sext      = {{(W-16){s_data[15]}}, s_data};

   // Port A carries either the loaded sample or the top butterfly result.
   assign w_wa_addr = w_run_we ? fft_i_top    : w_load_addr;
   assign w_wa_re   = w_run_we ? fft_y_top_re : w_sext;
   assign w_wa_im   = w_run_we ? fft_y_top_im : '0;

   // While unloading, read port A looks one bin ahead once the output register is full.
   assign w_rd_idx  = r_m_valid ? (r_out_idx + M'(1)) : r_out_idx;
   assign w_ra_addr = (r_state == ST_UNLOAD) ? w_rd_idx : fft_i_top;

   fft_frame_buf #(.N(N), .M(M), .W(W)) u_buf (
      .Clk       (Clk),
      .i_ra_addr (w_ra_addr),
      .o_ra_re   (fft_x_top_re),
      .o_ra_im   (fft_x_top_im),
      .i_rb_addr (fft_i_bot),
      .o_rb_re   (fft_x_bot_re),
      .o_rb_im   (fft_x_bot_im),
      .i_wa_en   (w_in_hs || w_run_we),
      .i_wa_addr (w_wa_addr),
      .i_wa_re   (w_wa_re),
      .i_wa_im   (w_wa_im),
      .i_wb_en   (w_run_we),
      .i_wb_addr (fft_i_bot),
      .i_wb_re   (fft_y_bot_re),
      .i_wb_im   (fft_y_bot_im)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= ST_IDLE;
         r_in_idx  <= '0;
         r_out_idx <= '0;
         r_start   <= 1'b0;
         r_ack     <= 1'b0;
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
         r_m_re    <= '0;
         r_m_im    <= '0;
      end else begin
         r_start <= 1'b0;
         r_ack   <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (s_valid) begin
                  r_in_idx <= M'(1);
                  r_state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (s_valid) begin
                  if (r_in_idx == LAST_IDX) begin
                     r_in_idx <= '0;
                     r_start  <= 1'b1;
                     r_state  <= ST_RUN;
                  end else begin
                     r_in_idx <= r_in_idx + M'(1);
                  end
               end
            end
            ST_RUN: begin
               if (fft_done) begin
                  r_ack   <= 1'b1;
                  r_state <= ST_ACK;
               end
            end
            ST_ACK: begin
               r_out_idx <= '0;
               r_m_valid <= 1'b0;
               r_state   <= ST_UNLOAD;
            end
            ST_UNLOAD: begin
               if (!r_m_valid) begin
                  r_m_re    <= fft_x_top_re;
                  r_m_im    <= fft_x_top_im;
                  r_m_last  <= (w_rd_idx == LAST_IDX);
                  r_m_valid <= 1'b1;
               end else if (m_ready) begin
                  if (r_m_last) begin
                     r_m_valid <= 1'b0;
                     r_m_last  <= 1'b0;
                     r_out_idx <= '0;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_out_idx <= w_rd_idx;
                     r_m_re    <= fft_x_top_re;
                     r_m_im    <= fft_x_top_im;
                     r_m_last  <= (w_rd_idx == LAST_IDX);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign fft_start = r_start;
   assign fft_ack   = r_ack;
   assign m_valid   = r_m_valid;
   assign m_last    = r_m_last;
   assign m_re      = r_m_re;
   assign m_im      = r_m_im;

`ifdef FFT_FRAME_CTRL_OVF_EN
   logic r_ovf;

   // |v| >= 2^(W-2): the top two bits differ, or v is exactly -2^(W-2).
   function automatic logic is_big(input logic [W-1:0] v);
      return (v[W-1] != v[W-2]) || ((v[W-1:W-2] == 2'b11) && (v[W-3:0] == '0));
   endfunction

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_ovf <= 1'b0;
      end else if ((r_state == ST_IDLE) && s_valid) begin
         r_ovf <= 1'b0;
      end else if (w_run_we && (is_big(fft_y_top_re) || is_big(fft_y_top_im) ||
                                is_big(fft_y_bot_re) || is_big(fft_y_bot_im))) begin
         r_ovf <= 1'b1;
      end
   end

   assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a behavioural radix-2 DIT core model.
// Define FFT_FRAME_CTRL_OVF_EN to also exercise the overflow flag (W=24).
module tb_fft_frame_ctrl;

   localparam int TN = 256;
   localparam int TM = 8;
`ifdef FFT_FRAME_CTRL_OVF_EN
   localparam int TW = 24;
`else
   localparam int TW = 32;
`endif
   localparam real PI = 3.14159265358979323846;

   logic                 Clk;
   logic                 Reset_n;
   logic                 s_valid;
   logic                 s_ready;
   logic signed [15:0]   s_data;
   logic                 m_valid;
   logic                 m_ready;
   logic signed [TW-1:0] m_re;
   logic signed [TW-1:0] m_im;
   logic                 m_last;
   logic                 fft_start;
   logic                 fft_ack;
   logic                 fft_proc;
   logic                 fft_done;
   logic [TM-1:0]        fft_i_top;
   logic [TM-1:0]        fft_i_bot;
   logic signed [TW-1:0] fft_x_top_re;
   logic signed [TW-1:0] fft_x_top_im;
   logic signed [TW-1:0] fft_x_bot_re;
   logic signed [TW-1:0] fft_x_bot_im;
   logic signed [TW-1:0] fft_y_top_re;
   logic signed [TW-1:0] fft_y_top_im;
   logic signed [TW-1:0] fft_y_bot_re;
   logic signed [TW-1:0] fft_y_bot_im;
   logic                 busy;
`ifdef FFT_FRAME_CTRL_OVF_EN
   logic                 ovf;
   logic                 ovf_at_done;
`endif

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int ack_miss = 0;
   int ack_bad = 0;
   int ack_seen = 0;
   bit core_bypass = 0;
   logic signed [TW-1:0] peek_top_re, peek_top_im, peek_bot_re;
   logic signed [TW-1:0] got_re [TN];
   logic signed [TW-1:0] got_im [TN];
   logic                 got_last [TN];

   fft_frame_ctrl #(.N(TN), .M(TM), .W(TW)) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_re         (m_re),
      .m_im         (m_im),
      .m_last       (m_last),
      .fft_start    (fft_start),
      .fft_ack      (fft_ack),
      .fft_proc     (fft_proc),
      .fft_done     (fft_done),
      .fft_i_top    (fft_i_top),
      .fft_i_bot    (fft_i_bot),
      .fft_x_top_re (fft_x_top_re),
      .fft_x_top_im (fft_x_top_im),
      .fft_x_bot_re (fft_x_bot_re),
      .fft_x_bot_im (fft_x_bot_im),
      .fft_y_top_re (fft_y_top_re),
      .fft_y_top_im (fft_y_top_im),
      .fft_y_bot_re (fft_y_bot_re),
      .fft_y_bot_im (fft_y_bot_im),
      .busy         (busy)
`ifdef FFT_FRAME_CTRL_OVF_EN
      ,
      .ovf          (ovf)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(negedge Clk) if (fft_start === 1'b1) start_cnt++;

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   function automatic int brev(input int v);
      int r = 0;
      for (int i = 0; i < TM; i++) if (v[i]) r |= (1 << (TM - 1 - i));
      return r;
   endfunction

   // DIT butterfly on the values currently presented by the read ports.
   task automatic butterfly(input int k, input int h);
      real ang, wr, wi, xtr, xti, xbr, xbi, tr, ti;
      ang = -2.0 * PI * real'(k) / real'(2 * h);
      wr  = $cos(ang);
      wi  = $sin(ang);
      xtr = real'(fft_x_top_re);
      xti = real'(fft_x_top_im);
      xbr = real'(fft_x_bot_re);
      xbi = real'(fft_x_bot_im);
      tr  = wr * xbr - wi * xbi;
      ti  = wr * xbi + wi * xbr;
      fft_y_top_re = TW'(longint'(xtr + tr));
      fft_y_top_im = TW'(longint'(xti + ti));
      fft_y_bot_re = TW'(longint'(xtr - tr));
      fft_y_bot_im = TW'(longint'(xti - ti));
   endtask

   initial begin : core_model
      bit abort;
      bit got;
      fft_proc = 1'b0; fft_done = 1'b0;
      fft_i_top = '0;  fft_i_bot = TM'(1);
      fft_y_top_re = '0; fft_y_top_im = '0; fft_y_bot_re = '0; fft_y_bot_im = '0;
      forever begin
         @(posedge Clk); #1;
         if (fft_start === 1'b1) begin
            abort = 1'b0;
            if (core_bypass) begin
               fft_i_top = TM'(128);
               fft_i_bot = TM'(192);
               #1;
               peek_top_re = fft_x_top_re;
               peek_top_im = fft_x_top_im;
               peek_bot_re = fft_x_bot_re;
            end else begin
               for (int s = 0; s < TM && !abort; s++)
                  for (int b = 0; b < TN && !abort; b += (2 << s))
                     for (int k = 0; k < (1 << s) && !abort; k++) begin
                        fft_proc  = 1'b1;
                        fft_i_top = TM'(b + k);
                        fft_i_bot = TM'(b + k + (1 << s));
                        #1;
                        butterfly(k, 1 << s);
                        @(posedge Clk); #1;
                        if (!Reset_n) abort = 1'b1;
                     end
               fft_proc = 1'b0;
            end
            if (!abort) begin
               fft_done = 1'b1;
`ifdef FFT_FRAME_CTRL_OVF_EN
               ovf_at_done = ovf;
`endif
               got = 1'b0;
               for (int t = 0; t < 20 && !got; t++) begin
                  @(posedge Clk); #1;
                  if (fft_ack === 1'b1) got = 1'b1;
               end
               fft_done = 1'b0;
               if (!got) ack_miss++;
               else begin
                  ack_seen++;
                  @(posedge Clk); #1;
                  if (fft_ack !== 1'b0) ack_bad++;
               end
            end
         end
      end
   end

   task automatic send_frame(input int first, input int rest, input int step);
      int s0;
      s0 = start_cnt;
      @(posedge Clk); #1;
      check("s_ready_idle", s_ready, 1);
      for (int n = 0; n < TN; n++) begin
         s_valid = 1'b1;
         s_data  = 16'((n == 0) ? first : rest + step * n);
         @(posedge Clk); #1;
      end
      s_valid = 1'b0;
      check("start_none_in_load", start_cnt, s0);
      check("fft_start_after_last", fft_start, 1);
      @(posedge Clk); #1;
      check("fft_start_one_cycle", fft_start, 0);
      check("start_count_frame", start_cnt, s0 + 1);
   endtask

   task automatic recv_frame(input int stall_bin);
      int idx = 0;
      int guard = 0;
      int hold_bad = 0;
      int stall = stall_bin;
      logic signed [TW-1:0] held;
      m_ready = 1'b1;
      while (idx < TN && guard < 4000) begin
         @(negedge Clk);
         guard++;
         if (m_valid === 1'b1) begin
            if (idx == 0) check("s_ready_unload", s_ready, 0);
            if (idx == stall) begin
               m_ready = 1'b0;
               held = m_re;
               repeat (5) begin
                  @(negedge Clk);
                  if (m_valid !== 1'b1 || m_re !== held) hold_bad++;
               end
               check("bp_hold_stable", hold_bad, 0);
               check("bp_held_value", held, brev(stall) - 2);
               m_ready = 1'b1;
               stall = -1;
            end
            got_re[idx]   = m_re;
            got_im[idx]   = m_im;
            got_last[idx] = m_last;
            idx++;
         end
      end
      check("recv_bin_count", idx, TN);
      $display("frame received: %0d bins, bin0 re=%0d im=%0d", idx, got_re[0], got_im[0]);
   endtask

   task automatic check_impulse(input string tag);
      int bad = 0;
      int lbad = 0;
      for (int k = 0; k < TN; k++) begin
         if (got_re[k] !== TW'(1000) || got_im[k] !== '0) bad++;
         if (got_last[k] !== ((k == TN - 1) ? 1'b1 : 1'b0)) lbad++;
      end
      check({tag, "_bins"}, bad, 0);
      check({tag, "_last"}, lbad, 0);
   endtask

   initial begin : main
      int bad;
      int ibad;
      int lbad;
      Reset_n = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      #1 Reset_n = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      check("rst_s_ready", s_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_last", m_last, 0);
      check("rst_m_re", m_re, 0);
      check("rst_m_im", m_im, 0);
      check("rst_fft_start", fft_start, 0);
      check("rst_fft_ack", fft_ack, 0);
      @(negedge Clk) Reset_n = 1'b1;

      // Ramp x[n]=n-2, core bypassed: output bin k is x[brev(k)].
      core_bypass = 1'b1;
      send_frame(-2, -2, 1);
      recv_frame(10);
      check("brev_sample1_at_128", peek_top_re, -1);
      check("brev_sample1_im", peek_top_im, 0);
      check("brev_sample3_at_192", peek_bot_re, 1);
      check("bp_bin9", got_re[9], 142);
      check("bp_bin10", got_re[10], 78);
      check("bp_bin11", got_re[11], 206);
      bad = 0; ibad = 0; lbad = 0;
      for (int k = 0; k < TN; k++) begin
         if (got_re[k] !== TW'(brev(k) - 2)) bad++;
         if (got_im[k] !== '0) ibad++;
         if (got_last[k] !== ((k == TN - 1) ? 1'b1 : 1'b0)) lbad++;
      end
      check("ramp_order_re", bad, 0);
      check("ramp_order_im", ibad, 0);
      check("ramp_last", lbad, 0);

      core_bypass = 1'b0;
      send_frame(1000, 0, 0);
      recv_frame(-1);
      check_impulse("impulse");

      send_frame(100, 100, 0);
      recv_frame(-1);
      check("dc_bin0_re", got_re[0], 25600);
      check("dc_bin0_im", got_im[0], 0);
      bad = 0;
      for (int k = 1; k < TN; k++) if (got_re[k] !== '0 || got_im[k] !== '0) bad++;
      check("dc_other_bins", bad, 0);

      // Abandon a frame mid-RUN, then a clean impulse frame.
      send_frame(1000, 0, 0);
      repeat (30) @(posedge Clk);
      #2;
      check("run_s_ready_low", s_ready, 0);
      check("run_busy", busy, 1);
      Reset_n = 1'b0;
      #1;
      check("rstrun_busy", busy, 0);
      check("rstrun_fft_start", fft_start, 0);
      check("rstrun_s_ready", s_ready, 1);
      check("rstrun_m_valid", m_valid, 0);
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      send_frame(1000, 0, 0);
      recv_frame(-1);
      check_impulse("impulse_after_reset");

`ifdef FFT_FRAME_CTRL_OVF_EN
      send_frame(32767, 32767, 0);
      recv_frame(-1);
      check("ovf_by_done", ovf_at_done, 1);
      check("ovf_sticky", ovf, 1);
      check("ovf_dc_bin0", got_re[0], 32767 * 256);
      send_frame(0, 0, 0);
      recv_frame(-1);
      check("ovf_zero_frame", ovf_at_done, 0);
      check("ovf_cleared", ovf, 0);
`endif

      check("ack_timeouts", ack_miss, 0);
      check("ack_not_single", ack_bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 Parameter N, default 256, FFT points per frame (power of 2).
REQ-002 Parameter M, default 8, log2(N); pass count of the butterfly core.
REQ-003 Parameter W, default 32, signed width of each real/imag buffer word.
REQ-004 Clk  in  1  sole clock, rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 s_valid/s_ready/s_data  in/out/in  1/1/16  signed real sample stream, time order.
REQ-007 m_valid/m_ready  out/in  1/1  result stream handshake.
REQ-008 m_re/m_im  out  W/W  result bin; m_last out 1 marks bin N-1.
REQ-009 fft_start/fft_ack  out  1/1  single-cycle pulses to butterfly core.
REQ-010 fft_proc/fft_done  in  1/1  core processing / done state bits.
REQ-011 fft_i_top/fft_i_bot  in  M/M  butterfly indices from core.
REQ-012 fft_x_top_re/im, fft_x_bot_re/im  out  W each  buffer words at fft_i_top/fft_i_bot, combinational read.
REQ-013 fft_y_top_re/im, fft_y_bot_re/im  in  W each  butterfly results.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 SHALL own an N-entry complex buffer (W re + W im per entry) with two combinational read ports and two write ports.
REQ-016 SHALL implement states IDLE, LOAD, RUN, ACK, UNLOAD; encoding one-hot.
REQ-017 IDLE: s_ready=1; first s_valid&&s_ready handshake is sample 0 and enters LOAD.
REQ-018 LOAD: s_ready=1; sample n written at bit-reverse(n) (M bits), re = sign-extended s_data, im = 0.
REQ-019 After handshake of sample N-1: fft_start=1 for exactly the next cycle, state RUN.
REQ-020 RUN: every cycle fft_proc=1, write y_top to fft_i_top and y_bot to fft_i_bot at Clk edge; no writes while fft_proc=0.
REQ-021 RUN: fft_done=1 -> state ACK; ACK drives fft_ack=1 for one cycle, then UNLOAD.
REQ-022 UNLOAD: bins 0..N-1 in natural order; m_re/m_im registered; index advances only on m_valid&&m_ready.
REQ-023 m_valid held with m_re/m_im/m_last stable while m_ready=0.
REQ-024 Handshake on bin N-1 (m_last=1) -> IDLE next cycle; s_ready reasserts in IDLE.
REQ-025 s_ready=0 in RUN, ACK, UNLOAD; s_valid ignored there.
REQ-026 Index counters wrap only at N-1 -> 0; no partial frames; all arithmetic unsigned M-bit.
REQ-027 fft_i_top==fft_i_bot never occurs; if it does, bottom write wins.

Reset
REQ-028 Reset_n low: state IDLE, counters 0, s_ready=1, m_valid=0, m_last=0, m_re=m_im=0, fft_start=0, fft_ack=0, busy=0.
REQ-029 Reset mid-LOAD/RUN/UNLOAD abandons the frame; buffer contents not cleared; first post-reset sample is sample 0.

Configuration
REQ-030 Macro FFT_FRAME_CTRL_OVF_EN: adds output ovf (1 bit), sticky per frame, set when any RUN write has |re| or |im| >= 2^(W-2); cleared on entering LOAD and by reset.
REQ-031 Without FFT_FRAME_CTRL_OVF_EN: no ovf port, no detection logic.

Structure
REQ-032 Shared package fft_pkg: N, M, W defaults, state enum, bit-reverse function.
REQ-033 One sub-module fft_frame_buf: 2R/2W complex register buffer.

Verification
REQ-034 Impulse: x[0]=1000, rest 0 -> all 256 bins re=1000, im=0; m_last only on bin 255.
REQ-035 DC: 256 samples of 100 -> bin 0 re=25600 im=0; bins 1..255 re=im=0.
REQ-036 Bit-reverse: after LOAD, sample 1 at addr 128, sample 3 at 192; fft_start pulses exactly once, cycle after sample 255.
REQ-037 Backpressure: m_ready low 5 cycles at bin 10 -> m_valid held, bin 10 value stable, no bin skipped.
REQ-038 Reset_n low during RUN -> IDLE, busy=0, fft_start=0; next full frame gives correct impulse result.
REQ-039 With FFT_FRAME_CTRL_OVF_EN, DC of 32767 with W=24 -> ovf=1 by fft_done; next frame of zeros -> ovf=0.
